seq_controller: RTL
===================

Name: seq_controller

Overview:
- Parametrised instruction-cycle sequencer; successor to the fixed 6-bit fetch/decode controller.
- Runs the fetch / interrupt-entry / decode / extension-word / memory-wait / I/O-handshake / execute sequence for the datapath.
- Opcode classes come from parameter bitmasks, not hard-coded case arms.
- Every wait state has a watchdog.
- Sits between the instruction/data memory interfaces, the I/O handshake pins and the datapath control decoder, which consumes exec + op_q.

Parameters:
- OPC_W, 6, opcode width; opcode space is 2**OPC_W.
- NUM_OPS, 46, opcodes >= NUM_OPS are illegal.
- LONG_MASK, 64'h0000_0700_2AAA_AAAA, bit n=1: opcode n needs an extension word.
- MEM_MASK, 64'h0000_000F_0000_0000, bit n=1: opcode n waits for data memory.
- IO_MASK, 64'h0000_00F0_0000_0000, bit n=1: opcode n performs the 4-phase I/O handshake.
- TMO_W, 8, watchdog counter width.
- TMO_CYC, 200, wait-state timeout in cycles; 0 disables the watchdog.

Ports:
- g_clk  in  1  system clock, rising edge.
- g_clr  in  1  asynchronous active-high reset.
- run  in  1  sequencer enable, sampled in IDLE.
- i_pending  in  1  interrupt request, level.
- opcode  in  OPC_W  opcode field, valid with i_odv in FETCH.
- i_odv  in  1  instruction word valid.
- d_odv  in  1  data word valid.
- hs_in  in  1  I/O handshake acknowledge.
- i_req  out  1  instruction memory request.
- ir_ld  out  1  load instruction register.
- ext_ld  out  1  load extension word.
- d_req  out  1  data memory request.
- hs_out  out  1  I/O handshake request.
- exec  out  1  execute strobe.
- op_q  out  OPC_W  latched opcode.
- int_save  out  1  save PC/flags strobe.
- int_ack  out  1  interrupt acknowledge / vector load.
- trap  out  1  illegal-opcode strobe.
- bus_err  out  1  watchdog timeout pulse.
- state_o  out  4  current state code, for debug.

Behaviour:
- Reset: g_clr=1 forces state IDLE, op_q=0, watchdog=0 and every output 0, asynchronously, including mid-handshake (hs_out drops immediately).
- Masks are indexed by opcode value; bits at or above 2**OPC_W are ignored.
- State codes: IDLE=0, INT_SAVE=1, INT_VEC=2, FETCH=3, DECODE=4, EXT=5, MEM=6, IO_REQ=7, IO_REL=8, EXEC=9, TRAP=10; codes 11-15 go to IDLE.
- IDLE: run=0 -> stay; else i_pending=1 -> INT_SAVE; else -> FETCH. Interrupts are taken only here, at instruction boundaries.
- INT_SAVE: int_save=1, then -> INT_VEC.
- INT_VEC: int_ack=1, then -> FETCH. Upstream clears i_pending off int_ack.
- FETCH: i_req=1. When i_odv=1: ir_ld=1 combinationally in that cycle, op_q<=opcode, -> DECODE.
- DECODE priority:
  - opcode>=NUM_OPS -> TRAP
  - LONG -> EXT
  - MEM -> MEM
  - IO -> IO_REQ
  - else -> EXEC
- EXT: i_req=1. When i_odv=1: ext_ld=1 combinationally; then MEM -> MEM, IO -> IO_REQ, else -> EXEC.
- MEM: d_req=1. When d_odv=1 -> EXEC. If both MEM and IO bits are set, MEM wins and the IO bit is ignored.
- IO_REQ: hs_out=1. When hs_in=1 -> IO_REL.
- IO_REL: hs_out=0. When hs_in=0 -> EXEC.
- EXEC: exec=1 for one cycle, op_q held, then -> IDLE.
- TRAP: trap=1 for one cycle, then -> IDLE. No exec for an illegal opcode.
- Watchdog:
  - Wait states are FETCH, EXT, MEM, IO_REQ and IO_REL.
  - Counter clears on every state change and counts cycles in which the awaited condition is false.
  - On the TMO_CYC-th such cycle: -> IDLE, and bus_err=1 (registered) for the next cycle only.
  - A handshake arriving in the timeout cycle wins; no bus_err.
  - TMO_CYC=0: never times out.
  - Counter saturates and does not wrap.
- Latency with zero-wait memory: short op is 4 cycles IDLE->IDLE, exec in cycle 3 after leaving IDLE; long op 5 cycles; interrupt entry adds 2.
- All state-based outputs are Moore decodes of the state register; ir_ld and ext_ld are the only Mealy outputs.

Test Plan:
- Reset, then run=1, opcode=6'o00, i_odv=1 in FETCH -> ir_ld in cycle 1, exec in cycle 3 with op_q=0, back in IDLE in cycle 4.
- opcode=6'o01 with i_odv held low 3 cycles in EXT -> ext_ld on the 4th EXT cycle, exec on the next cycle, op_q=6'o01.
- opcode=6'o44 (IO): hs_in rises 2 cycles after hs_out; hs_out then falls; hs_in falls 1 cycle later -> exec the cycle after; hs_out high exactly 3 cycles.
- i_pending=1 in IDLE -> int_save, int_ack, then i_req, all on consecutive cycles; with i_pending held, a second entry occurs only at the next IDLE.
- opcode=6'o56 -> trap one cycle after DECODE, exec never asserted; opcode=6'o40 with d_odv low 200 cycles -> bus_err one cycle, state_o=0.
- g_clr pulsed during IO_REQ -> hs_out=0 and state_o=0 without a clock edge; i_odv asserted on the same cycle the timeout expires -> no bus_err.

Source files
------------

// File: rtl/seq_controller.sv
// Instruction-cycle sequencer: fetch, interrupt entry, decode, extension word,
// memory wait, 4-phase I/O handshake and execute, with a watchdog on every wait state.
module seq_controller #(
    parameter int unsigned OPC_W     = 6,
    parameter int unsigned NUM_OPS   = 46,
    parameter logic [63:0] LONG_MASK = 64'h0000_0700_2AAA_AAAA,
    parameter logic [63:0] MEM_MASK  = 64'h0000_000F_0000_0000,
    parameter logic [63:0] IO_MASK   = 64'h0000_00F0_0000_0000,
    parameter int unsigned TMO_W     = 8,
    parameter int unsigned TMO_CYC   = 200
) (
    input  logic             g_clk,
    input  logic             g_clr,
    input  logic             run,
    input  logic             i_pending,
    input  logic [OPC_W-1:0] opcode,
    input  logic             i_odv,
    input  logic             d_odv,
    input  logic             hs_in,
    output logic             i_req,
    output logic             ir_ld,
    output logic             ext_ld,
    output logic             d_req,
    output logic             hs_out,
    output logic             exec,
    output logic [OPC_W-1:0] op_q,
    output logic             int_save,
    output logic             int_ack,
    output logic             trap,
    output logic             bus_err,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INT_SAVE = 4'd1,
        S_INT_VEC  = 4'd2,
        S_FETCH    = 4'd3,
        S_DECODE   = 4'd4,
        S_EXT      = 4'd5,
        S_MEM      = 4'd6,
        S_IO_REQ   = 4'd7,
        S_IO_REL   = 4'd8,
        S_EXEC     = 4'd9,
        S_TRAP     = 4'd10
    } state_e;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] wdog_q, wdog_d;
    logic             bus_err_q;

    // Mask lookup by opcode value; mask bits beyond the opcode space are never reached.
    function automatic logic mask_bit(input logic [63:0] mask, input logic [OPC_W-1:0] op);
        logic b;
        b = 1'b0;
        for (int unsigned n = 0; n < 64; n++) begin
            if (32'(op) == n) b = mask[n];
        end
        return b;
    endfunction

    logic is_ill_c, is_long_c, is_mem_c, is_io_c;
    logic waiting_c, cond_c, stall_c, tmo_c;

    always_comb begin
        is_ill_c  = (32'(op_q) >= NUM_OPS);
        is_long_c = mask_bit(LONG_MASK, op_q);
        is_mem_c  = mask_bit(MEM_MASK, op_q);
        is_io_c   = mask_bit(IO_MASK, op_q);
    end

    // Watchdog: a stall is a wait-state cycle whose awaited condition is false.
    always_comb begin
        waiting_c = 1'b0;
        cond_c    = 1'b0;
        case (state_q)
            S_FETCH, S_EXT: begin waiting_c = 1'b1; cond_c = i_odv;  end
            S_MEM:          begin waiting_c = 1'b1; cond_c = d_odv;  end
            S_IO_REQ:       begin waiting_c = 1'b1; cond_c = hs_in;  end
            S_IO_REL:       begin waiting_c = 1'b1; cond_c = !hs_in; end
            default:        ;
        endcase
        stall_c = waiting_c && !cond_c;
        tmo_c   = stall_c && (TMO_CYC != 0)
                  && ((64'(wdog_q) + 64'd1) >= 64'(TMO_CYC));
    end

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            state_q   <= S_IDLE;
            wdog_q    <= '0;
            bus_err_q <= 1'b0;
            op_q      <= '0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            bus_err_q <= tmo_c;
            if (state_q == S_FETCH && i_odv) op_q <= opcode;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (run) state_d = i_pending ? S_INT_SAVE : S_FETCH;
            S_INT_SAVE: state_d = S_INT_VEC;
            S_INT_VEC:  state_d = S_FETCH;
            S_FETCH:    if (i_odv) state_d = S_DECODE;
            S_DECODE: begin
                if (is_ill_c)       state_d = S_TRAP;
                else if (is_long_c) state_d = S_EXT;
                else if (is_mem_c)  state_d = S_MEM;
                else if (is_io_c)   state_d = S_IO_REQ;
                else                state_d = S_EXEC;
            end
            S_EXT: begin
                if (i_odv) begin
                    if (is_mem_c)     state_d = S_MEM;
                    else if (is_io_c) state_d = S_IO_REQ;
                    else              state_d = S_EXEC;
                end
            end
            S_MEM:      if (d_odv) state_d = S_EXEC;
            S_IO_REQ:   if (hs_in) state_d = S_IO_REL;
            S_IO_REL:   if (!hs_in) state_d = S_EXEC;
            S_EXEC:     state_d = S_IDLE;
            S_TRAP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (tmo_c) state_d = S_IDLE;
    end

    // Counter restarts on any state change and saturates rather than wrapping.
    always_comb begin
        wdog_d = wdog_q;
        if (state_d != state_q)
            wdog_d = '0;
        else if (stall_c && (wdog_q != '1))
            wdog_d = wdog_q + TMO_W'(1);
    end

    always_comb begin
        i_req    = 1'b0;
        ir_ld    = 1'b0;
        ext_ld   = 1'b0;
        d_req    = 1'b0;
        hs_out   = 1'b0;
        exec     = 1'b0;
        int_save = 1'b0;
        int_ack  = 1'b0;
        trap     = 1'b0;
        case (state_q)
            S_INT_SAVE: int_save = 1'b1;
            S_INT_VEC:  int_ack  = 1'b1;
            S_FETCH:    begin i_req = 1'b1; ir_ld  = i_odv; end
            S_EXT:      begin i_req = 1'b1; ext_ld = i_odv; end
            S_MEM:      d_req  = 1'b1;
            S_IO_REQ:   hs_out = 1'b1;
            S_EXEC:     exec   = 1'b1;
            S_TRAP:     trap   = 1'b1;
            default:    ;
        endcase
    end

    assign bus_err = bus_err_q;
    assign state_o = state_q;

endmodule
